// File: rtl/calculadora_param.sv
// Parametrised calculator: seven single-cycle operations plus a WIDTH-cycle
// shift-add multiply, with a valid/busy handshake and carry/overflow/zero flags.
module calculadora_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       MODO,
  output logic [WIDTH-1:0] c,
  output logic             valid,
  output logic             busy,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_ACC = 3'b110,
    OP_CLR = 3'b111
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               valid_q, valid_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  op_e                op;
  logic [WIDTH-1:0]   add_lhs, add_rhs;
  logic [WIDTH:0]     sum, diff;
  logic               add_ovf, sub_ovf;
  logic [2*WIDTH-1:0] prod_next;
  logic               write;
  logic [WIDTH-1:0]   res_c;
  logic               res_carry, res_ovf;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    c_d       = c_q;
    valid_d   = 1'b0;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    write     = 1'b0;
    res_c     = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;

    op        = op_e'(MODO);
    // ACC reuses the adder with the current result as the left operand.
    add_lhs   = (op == OP_ACC) ? c_q : a;
    add_rhs   = (op == OP_ACC) ? a : b;
    sum       = {1'b0, add_lhs} + {1'b0, add_rhs};
    diff      = {1'b0, a} - {1'b0, b};
    add_ovf   = (add_lhs[MSB] == add_rhs[MSB]) && (sum[MSB] != add_lhs[MSB]);
    sub_ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
    prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            write = 1'b1;
            unique case (op)
              OP_ADD, OP_ACC: begin
                res_c     = sum[MSB:0];
                res_carry = sum[WIDTH];
                res_ovf   = add_ovf;
              end
              OP_SUB: begin
                res_c     = diff[MSB:0];
                res_carry = diff[WIDTH];
                res_ovf   = sub_ovf;
              end
              OP_AND:  res_c = a & b;
              OP_OR:   res_c = a | b;
              OP_XOR:  res_c = a ^ b;
              default: res_c = '0;
            endcase
          end
        end
      end
      S_MUL: begin
        // One multiplier bit per edge, LSB first; the last step writes the result.
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_IDLE;
          write   = 1'b1;
          res_c   = prod_next[MSB:0];
          res_ovf = |prod_next[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (write) begin
      c_d     = res_c;
      carry_d = res_carry;
      ovf_d   = res_ovf;
      zero_d  = (res_c == '0);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      valid_q  <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      // NOTE: the multiply datapath registers are reset as well, so an aborted multiply leaves no stale state behind.
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values, independent of statement order.
      state_q  <= state_d;
      c_q      <= c_d;
      valid_q  <= valid_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign c     = c_q;
  assign valid = valid_q;
  assign busy  = (state_q == S_MUL);
  assign carry = carry_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_calculadora_param.sv
// Self-checking bench for calculadora_param: directed vector table, hand-written
// multi-cycle sequences and random operations against an arithmetic model.
module tb_calculadora_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic [2:0]   modo_i = 3'b000;
  logic [W-1:0] c_o;
  logic         valid_o, busy_o, carry_o, ovf_o, zero_o;

  logic         en16 = 1'b0;
  logic [15:0]  a16 = '0, b16 = '0;
  logic [2:0]   modo16 = 3'b000;
  logic [15:0]  c16;
  logic         valid16, busy16, carry16, ovf16, zero16;

  int checks = 0;
  int failures = 0;
  int model_c = 0;

  always #5 clk = ~clk;

  calculadora_param #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en_i), .a(a_i), .b(b_i), .MODO(modo_i),
    .c(c_o), .valid(valid_o), .busy(busy_o), .carry(carry_o), .ovf(ovf_o), .zero(zero_o)
  );

  calculadora_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .a(a16), .b(b16), .MODO(modo16),
    .c(c16), .valid(valid16), .busy(busy16), .carry(carry16), .ovf(ovf16), .zero(zero16)
  );

  typedef struct {
    int c;
    bit carry;
    bit ovf;
  } res_t;

  typedef struct {
    string    name;
    bit [2:0] mode;
    int       a;
    int       b;
    int       exp_c;
    bit       exp_carry;
    bit       exp_ovf;
  } vec_t;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic int to_signed8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reference behaviour from plain integer arithmetic on 8-bit values.
  function automatic res_t model(input bit [2:0] m, input int a, input int b, input int cprev);
    res_t r;
    int s;
    r = '{c: 0, carry: 1'b0, ovf: 1'b0};
    case (m)
      3'd0, 3'd6: begin
        int x;
        int y;
        x = (m == 3'd6) ? cprev : a;
        y = (m == 3'd6) ? a : b;
        s = x + y;
        r.c = s % 256;
        r.carry = (s > 255);
        s = to_signed8(x) + to_signed8(y);
        r.ovf = (s > 127) || (s < -128);
      end
      3'd1: begin
        r.c = (a - b + 256) % 256;
        r.carry = (a < b);
        s = to_signed8(a) - to_signed8(b);
        r.ovf = (s > 127) || (s < -128);
      end
      3'd2: begin
        s = a * b;
        r.c = s % 256;
        r.ovf = (s > 255);
      end
      3'd3: r.c = a & b;
      3'd4: r.c = a | b;
      3'd5: r.c = a ^ b;
      default: r.c = 0;
    endcase
    return r;
  endfunction

  // Issue one request and wait (bounded) for valid; latency counts negedges from the issuing edge.
  task automatic do_op(input bit [2:0] m, input int a, input int b,
                       output int lat, output int busy_n, output bit got_valid);
    @(negedge clk);
    en_i = 1'b1; modo_i = m; a_i = W'(a); b_i = W'(b);
    @(negedge clk);
    en_i = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!valid_o && lat < 4 * W) begin
      if (busy_o) busy_n++;
      @(negedge clk);
      lat++;
    end
    got_valid = valid_o;
  endtask

  task automatic op_and_check(input string name, input bit [2:0] m, input int a, input int b,
                              input int exp_c, input bit exp_carry, input bit exp_ovf);
    int lat, busy_n;
    bit got_valid;
    do_op(m, a, b, lat, busy_n, got_valid);
    check({name, ".valid"}, got_valid, 1);
    check({name, ".c"}, c_o, exp_c);
    check({name, ".carry"}, carry_o, exp_carry);
    check({name, ".ovf"}, ovf_o, exp_ovf);
    check({name, ".zero"}, zero_o, exp_c == 0);
    check({name, ".latency"}, lat, (m == 3'd2) ? W + 1 : 1);
    check({name, ".busy_cycles"}, busy_n, (m == 3'd2) ? W : 0);
    check({name, ".busy_end"}, busy_o, 0);
    model_c = exp_c;
    @(negedge clk);
    check({name, ".valid_drop"}, valid_o, 0);
  endtask

  initial begin
    vec_t vecs[$];
    int lat, busy_n, vcount;
    bit got_valid;
    res_t r;

    // Reset state
    @(negedge clk);
    check("rst.c", c_o, 0);
    check("rst.valid", valid_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.carry", carry_o, 0);
    check("rst.ovf", ovf_o, 0);
    check("rst.zero", zero_o, 1);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle.outputs", {c_o, valid_o, busy_o, carry_o, ovf_o, zero_o}, {8'd0, 5'b00001});
    end

    // Directed vector table
    vecs.push_back('{"add_200_100", 3'd0, 200, 100, 44, 1'b1, 1'b0});
    vecs.push_back('{"add_7f_1", 3'd0, 8'h7F, 1, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{"sub_80_1", 3'd1, 8'h80, 1, 8'h7F, 1'b0, 1'b1});
    vecs.push_back('{"sub_5_7", 3'd1, 5, 7, 254, 1'b1, 1'b0});
    vecs.push_back('{"mul_15_17", 3'd2, 15, 17, 255, 1'b0, 1'b0});
    vecs.push_back('{"mul_16_16", 3'd2, 16, 16, 0, 1'b0, 1'b1});
    vecs.push_back('{"clr", 3'd7, 9, 9, 0, 1'b0, 1'b0});
    vecs.push_back('{"acc_1", 3'd6, 100, 0, 100, 1'b0, 1'b0});
    vecs.push_back('{"acc_2", 3'd6, 100, 0, 200, 1'b0, 1'b1});
    vecs.push_back('{"acc_3", 3'd6, 100, 0, 44, 1'b1, 1'b0});
    vecs.push_back('{"and", 3'd3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0});
    vecs.push_back('{"or", 3'd4, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0});
    vecs.push_back('{"xor", 3'd5, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0});
    foreach (vecs[i])
      op_and_check(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b,
                   vecs[i].exp_c, vecs[i].exp_carry, vecs[i].exp_ovf);

    // en held high with an ADD during a multiply, then taken the cycle after busy falls
    @(negedge clk);
    en_i = 1'b1; modo_i = 3'd2; a_i = 8'd15; b_i = 8'd17;
    @(negedge clk);
    modo_i = 3'd0; a_i = 8'd1; b_i = 8'd1;
    lat = 1;
    while (!valid_o && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    check("mul_ign.latency", lat, W + 1);
    check("mul_ign.c", c_o, 255);
    check("mul_ign.valid", valid_o, 1);
    @(negedge clk);
    en_i = 1'b0;
    check("b2b_add.valid", valid_o, 1);
    check("b2b_add.c", c_o, 2);
    model_c = 2;
    @(negedge clk);
    check("b2b_add.valid_drop", valid_o, 0);

    // Random operations against the model
    for (int i = 0; i < 60; i++) begin
      bit [2:0] m;
      int ra, rb;
      m = 3'($urandom_range(0, 7));
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      r = model(m, ra, rb, model_c);
      op_and_check($sformatf("rand%0d_m%0d_%0d_%0d", i, m, ra, rb), m, ra, rb, r.c, r.carry, r.ovf);
    end

    // Reset in the third cycle of a multiply
    op_and_check("pre_abort_add", 3'd0, 1, 2, 3, 1'b0, 1'b0);
    @(negedge clk);
    en_i = 1'b1; modo_i = 3'd2; a_i = 8'd7; b_i = 8'd9;
    @(negedge clk);
    en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort.busy_before", busy_o, 1);
    #2 rst = 1'b0;
    #1;
    check("abort.c", c_o, 0);
    check("abort.busy", busy_o, 0);
    check("abort.valid", valid_o, 0);
    check("abort.zero", zero_o, 1);
    check("abort.flags", {carry_o, ovf_o}, 0);
    @(negedge clk);
    rst = 1'b1;
    model_c = 0;
    vcount = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    check("abort.no_valid", vcount, 0);
    op_and_check("mul_3_4", 3'd2, 3, 4, 12, 1'b0, 1'b0);

    // Wider instance
    @(negedge clk);
    en16 = 1'b1; modo16 = 3'd2; a16 = 16'd300; b16 = 16'd300;
    @(negedge clk);
    en16 = 1'b0;
    lat = 1;
    while (!valid16 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("w16.valid", valid16, 1);
    check("w16.latency", lat, 17);
    check("w16.c", c16, 24464);
    check("w16.ovf", ovf16, 1);
    check("w16.carry_zero", {carry16, zero16}, 0);
    check("w16.busy_end", busy16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
